// File: rtl/ymem_arb_if.sv
// Bundle of the two requester ports plus the shared single-port memory bus.
// The slave modport is the arbiter's view; master is the requesters/memory side.
interface ymem_arb_if #(
  parameter int W = 32
);
  logic         req0;
  logic         req1;
  logic [W-1:0] addr0;
  logic [W-1:0] addr1;
  logic         we0;
  logic         we1;
  logic [W-1:0] wdata0;
  logic [W-1:0] wdata1;
  logic         gnt0;
  logic         gnt1;
  logic         done0;
  logic         done1;
  logic [W-1:0] rdata;
  logic         mem_en;
  logic         mem_we;
  logic [W-1:0] mem_addr;
  logic [W-1:0] mem_wdata;
  logic [W-1:0] mem_rdata;

  modport slave (
    input  req0, req1, addr0, addr1, we0, we1, wdata0, wdata1, mem_rdata,
    output gnt0, gnt1, done0, done1, rdata, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req0, req1, addr0, addr1, we0, we1, wdata0, wdata1, mem_rdata,
    input  gnt0, gnt1, done0, done1, rdata, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/ymem_arb.sv
// Round-robin arbiter of fetch (port 0) and data (port 1) onto one memory; grant to done is LAT cycles.
// Requesters stall by holding req until done; one access in flight, 2-cycle turnaround between grants.
module ymem_arb #(
  parameter int W   = 32,
  parameter int LAT = 2
) (
  input  logic         clk,
  input  logic         reset,
  ymem_arb_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t       state_q,     state_d;
  logic [3:0]   cnt_q,       cnt_d;
  logic         last_q,      last_d;
  logic         sel_q,       sel_d;
  logic         gnt0_q,      gnt0_d;
  logic         gnt1_q,      gnt1_d;
  logic         done0_q,     done0_d;
  logic         done1_q,     done1_d;
  logic [W-1:0] rdata_q,     rdata_d;
  logic         mem_en_q,    mem_en_d;
  logic         mem_we_q,    mem_we_d;
  logic [W-1:0] mem_addr_q,  mem_addr_d;
  logic [W-1:0] mem_wdata_q, mem_wdata_d;
  logic         win1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    sel_d       = sel_q;
    rdata_d     = rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    done0_d     = 1'b0;
    done1_d     = 1'b0;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    // On a tie port 1 wins only if port 0 was granted last.
    win1        = bus.req1 & (~bus.req0 | ~last_q);

    case (state_q)
      IDLE: begin
        if (bus.req0 | bus.req1) begin
          sel_d       = win1;
          last_d      = win1;
          gnt0_d      = ~win1;
          gnt1_d      = win1;
          mem_addr_d  = win1 ? bus.addr1  : bus.addr0;
          mem_wdata_d = win1 ? bus.wdata1 : bus.wdata0;
          mem_we_d    = win1 ? bus.we1    : bus.we0;
          mem_en_d    = 1'b1;
          cnt_d       = 4'(LAT);
          state_d     = BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          done0_d = ~sel_q;
          done1_d = sel_q;
          if (!mem_we_q) begin
            rdata_d = bus.mem_rdata;
          end
        end else begin
          mem_en_d = 1'b1;
          mem_we_d = mem_we_q;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      last_q      <= 1'b1;
      sel_q       <= 1'b0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      rdata_q     <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      sel_q       <= sel_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      done0_q     <= done0_d;
      done1_q     <= done1_d;
      rdata_q     <= rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus.gnt0      = gnt0_q;
  assign bus.gnt1      = gnt1_q;
  assign bus.done0     = done0_q;
  assign bus.done1     = done1_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_ymem_arb.sv
// Bench for ymem_arb: directed scenarios plus randomized transactions against a transaction-level model.
// Instance A runs LAT=2, instance B runs LAT=1.
module tb_ymem_arb;
  localparam int W     = 32;
  localparam int LAT_A = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ymem_arb_if #(.W(W)) bus_a ();
  ymem_arb_if #(.W(W)) bus_b ();

  ymem_arb #(.W(W), .LAT(LAT_A)) u_dut  (.clk(clk), .reset(reset), .bus(bus_a.slave));
  ymem_arb #(.W(W), .LAT(1))     u_dut1 (.clk(clk), .reset(reset), .bus(bus_b.slave));

  int n_tests = 0;
  int n_fail  = 0;
  int viol    = 0;
  bit       last_model;
  logic [W-1:0] model_rd;

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if ($countones({bus_a.gnt0, bus_a.gnt1, bus_a.done0, bus_a.done1}) > 1) viol++;
      if ($countones({bus_b.gnt0, bus_b.gnt1, bus_b.done0, bus_b.done1}) > 1) viol++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus_a.req0 = 0; bus_a.req1 = 0; bus_a.we0 = 0; bus_a.we1 = 0;
    bus_a.addr0 = '0; bus_a.addr1 = '0; bus_a.wdata0 = '0; bus_a.wdata1 = '0; bus_a.mem_rdata = '0;
    bus_b.req0 = 0; bus_b.req1 = 0; bus_b.we0 = 0; bus_b.we1 = 0;
    bus_b.addr0 = '0; bus_b.addr1 = '0; bus_b.wdata0 = '0; bus_b.wdata1 = '0; bus_b.mem_rdata = '0;
  endtask

  // Follows one transaction on instance A from request to done and records what it saw.
  task automatic collect(input bit scramble, input bit drop, output int gport, output int wcyc,
                         output int en_cnt, output logic [W-1:0] m_addr, output logic m_we,
                         output logic [W-1:0] m_wdata, output bit stable, output int dport,
                         output int doff, output bit en_at_done, output logic [W-1:0] rd);
    gport = -1; wcyc = 0; en_cnt = 0; stable = 1; dport = -1; doff = -1; en_at_done = 0;
    m_addr = '0; m_we = 0; m_wdata = '0; rd = '0;
    for (int i = 0; i < 40 && gport < 0; i++) begin
      tick();
      wcyc++;
      if (bus_a.gnt0) gport = 0;
      else if (bus_a.gnt1) gport = 1;
    end
    if (gport < 0) return;
    m_addr = bus_a.mem_addr; m_we = bus_a.mem_we; m_wdata = bus_a.mem_wdata;
    if (drop) begin bus_a.req0 = 0; bus_a.req1 = 0; end
    if (scramble) begin
      bus_a.addr0 = $urandom; bus_a.addr1 = $urandom; bus_a.wdata0 = $urandom; bus_a.wdata1 = $urandom;
      bus_a.we0 = 1'($urandom_range(0, 1)); bus_a.we1 = 1'($urandom_range(0, 1));
    end
    for (int k = 0; k <= LAT_A + 2 && dport < 0; k++) begin
      if (k > 0) tick();
      if (bus_a.done0) dport = 0;
      else if (bus_a.done1) dport = 1;
      if (dport >= 0) begin
        doff = k; en_at_done = bus_a.mem_en; rd = bus_a.rdata;
      end else if (bus_a.mem_en) begin
        en_cnt++;
        if (bus_a.mem_addr !== m_addr || bus_a.mem_we !== m_we || bus_a.mem_wdata !== m_wdata) stable = 0;
      end
    end
  endtask

  int gp, wc, ec, dp, dof;
  logic [W-1:0] ma, mwd, rdv;
  logic mw;
  bit st, ead;

  task automatic test_reset();
    reset = 1; bus_a.req0 = 1; bus_a.req1 = 1; bus_b.req0 = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if ({bus_a.gnt0, bus_a.gnt1, bus_a.done0, bus_a.done1, bus_a.mem_en, bus_a.mem_we,
           bus_a.mem_addr, bus_a.mem_wdata, bus_a.rdata} !== '0) begin
        n_fail++; $display("FAIL reset_outputs cycle %0d: gnt=%b%b en=%b addr=%h rdata=%h, required all 0",
                           i, bus_a.gnt0, bus_a.gnt1, bus_a.mem_en, bus_a.mem_addr, bus_a.rdata);
      end
    end
    idle_inputs();
    reset = 0;
    last_model = 1; model_rd = '0;
    tick();
    n_tests++;
    if ({bus_a.gnt0, bus_a.gnt1, bus_b.gnt0} !== 3'b000) begin
      n_fail++; $display("FAIL reset_req_ignored: gnt=%b%b%b, required 000", bus_a.gnt0, bus_a.gnt1, bus_b.gnt0);
    end
  endtask

  task automatic test_single_read();
    bus_a.mem_rdata = 32'hCAFE; bus_a.req0 = 1; bus_a.addr0 = 32'h10; bus_a.we0 = 0;
    collect(0, 0, gp, wc, ec, ma, mw, mwd, st, dp, dof, ead, rdv);
    bus_a.req0 = 0;
    n_tests++; if (gp !== 0) begin n_fail++; $display("FAIL read_gnt_port got %0d need 0", gp); end
    n_tests++; if (ma !== 32'h10 || mw !== 1'b0 || !st) begin n_fail++; $display("FAIL read_mem_bus addr=%h we=%b stable=%0d need 10/0/1", ma, mw, st); end
    n_tests++; if (ec !== LAT_A || ead !== 1'b0) begin n_fail++; $display("FAIL read_en_cycles got %0d (en at done %b) need %0d (0)", ec, ead, LAT_A); end
    n_tests++; if (dp !== 0 || dof !== LAT_A) begin n_fail++; $display("FAIL read_done port %0d at +%0d need 0 at +%0d", dp, dof, LAT_A); end
    n_tests++; if (rdv !== 32'hCAFE) begin n_fail++; $display("FAIL read_rdata got %h need cafe", rdv); end
    last_model = 0; model_rd = 32'hCAFE;
  endtask

  task automatic test_write();
    tick(); tick();
    bus_a.mem_rdata = 32'hDEAD; bus_a.req1 = 1; bus_a.we1 = 1; bus_a.addr1 = 32'h20; bus_a.wdata1 = 32'h55;
    collect(0, 0, gp, wc, ec, ma, mw, mwd, st, dp, dof, ead, rdv);
    bus_a.req1 = 0; bus_a.we1 = 0;
    n_tests++; if (gp !== 1) begin n_fail++; $display("FAIL write_gnt_port got %0d need 1", gp); end
    n_tests++; if (ma !== 32'h20 || mw !== 1'b1 || mwd !== 32'h55 || !st) begin n_fail++; $display("FAIL write_mem_bus addr=%h we=%b wdata=%h stable=%0d need 20/1/55/1", ma, mw, mwd, st); end
    n_tests++; if (ec !== LAT_A) begin n_fail++; $display("FAIL write_en_cycles got %0d need %0d", ec, LAT_A); end
    n_tests++; if (dp !== 1 || dof !== LAT_A) begin n_fail++; $display("FAIL write_done port %0d at +%0d need 1 at +%0d", dp, dof, LAT_A); end
    n_tests++; if (rdv !== model_rd) begin n_fail++; $display("FAIL write_rdata_kept got %h need %h", rdv, model_rd); end
    last_model = 1;
  endtask

  task automatic test_tie();
    reset = 1; tick(); reset = 0; last_model = 1; model_rd = '0;
    bus_a.mem_rdata = 32'h1234; bus_a.req0 = 1; bus_a.req1 = 1; bus_a.addr0 = 32'h100; bus_a.addr1 = 32'h200;
    for (int n = 0; n < 3; n++) begin
      collect(0, 0, gp, wc, ec, ma, mw, mwd, st, dp, dof, ead, rdv);
      n_tests++; if (gp !== (n % 2)) begin n_fail++; $display("FAIL tie_order grant %0d port %0d need %0d", n, gp, n % 2); end
      n_tests++; if (ma !== ((n % 2) ? 32'h200 : 32'h100)) begin n_fail++; $display("FAIL tie_addr grant %0d addr %h", n, ma); end
      if (n > 0) begin
        n_tests++; if (wc !== 2) begin n_fail++; $display("FAIL tie_spacing grant %0d waited %0d after done need 2", n, wc); end
      end
    end
    bus_a.req0 = 0; bus_a.req1 = 0;
    last_model = 0; model_rd = 32'h1234;
  endtask

  task automatic test_drop();
    int extra;
    tick(); tick();
    bus_a.mem_rdata = 32'h4444; bus_a.req0 = 1; bus_a.addr0 = 32'h44; bus_a.we0 = 0;
    collect(1, 1, gp, wc, ec, ma, mw, mwd, st, dp, dof, ead, rdv);
    bus_a.req0 = 0; bus_a.req1 = 0;
    n_tests++; if (gp !== 0 || ma !== 32'h44 || !st) begin n_fail++; $display("FAIL drop_grant port %0d addr %h stable %0d need 0/44/1", gp, ma, st); end
    n_tests++; if (dp !== 0 || dof !== LAT_A) begin n_fail++; $display("FAIL drop_done port %0d at +%0d need 0 at +%0d", dp, dof, LAT_A); end
    n_tests++; if (rdv !== 32'h4444) begin n_fail++; $display("FAIL drop_rdata got %h need 4444", rdv); end
    extra = 0;
    for (int i = 0; i < 5; i++) begin tick(); if (bus_a.gnt0 | bus_a.gnt1) extra++; end
    n_tests++; if (extra !== 0) begin n_fail++; $display("FAIL drop_no_regrant saw %0d grants need 0", extra); end
    last_model = 0; model_rd = 32'h4444;
  endtask

  task automatic test_reset_busy();
    int seen, dn;
    seen = 0;
    bus_a.req1 = 1; bus_a.addr1 = 32'h80; bus_a.we1 = 1; bus_a.wdata1 = 32'h99;
    for (int i = 0; i < 20 && !seen; i++) begin tick(); if (bus_a.gnt1) seen = 1; end
    n_tests++; if (!seen) begin n_fail++; $display("FAIL rstbusy_gnt1 no grant within 20 cycles"); end
    tick();
    reset = 1; bus_a.req1 = 0;
    tick();
    n_tests++;
    if ({bus_a.gnt0, bus_a.gnt1, bus_a.done0, bus_a.done1, bus_a.mem_en, bus_a.mem_we,
         bus_a.mem_addr, bus_a.mem_wdata, bus_a.rdata} !== '0) begin
      n_fail++; $display("FAIL rstbusy_outputs en=%b we=%b addr=%h done1=%b, required all 0",
                         bus_a.mem_en, bus_a.mem_we, bus_a.mem_addr, bus_a.done1);
    end
    reset = 0; last_model = 1; model_rd = '0;
    dn = 0;
    for (int i = 0; i < 6; i++) begin tick(); if (bus_a.done0 | bus_a.done1 | bus_a.mem_en) dn++; end
    n_tests++; if (dn !== 0) begin n_fail++; $display("FAIL rstbusy_no_done saw %0d done/en cycles need 0", dn); end
    bus_a.mem_rdata = 32'h7777; bus_a.req0 = 1; bus_a.req1 = 1; bus_a.we0 = 0; bus_a.we1 = 0;
    collect(0, 0, gp, wc, ec, ma, mw, mwd, st, dp, dof, ead, rdv);
    bus_a.req0 = 0; bus_a.req1 = 0;
    n_tests++; if (gp !== 0) begin n_fail++; $display("FAIL rstbusy_tie port %0d need 0", gp); end
    last_model = 0; model_rd = 32'h7777;
  endtask

  task automatic test_random();
    int g, ep, ew;
    bit r0, r1, drop;
    logic [1:0] sel;
    logic [W-1:0] a0, a1, d0, d1, rv;
    logic w0, w1;
    for (int it = 0; it < 40; it++) begin
      g = (it == 0) ? 3 : $urandom_range(0, 2);
      repeat (g) tick();
      sel = 2'($urandom_range(1, 3)); r0 = sel[0]; r1 = sel[1];
      a0 = $urandom; a1 = $urandom; d0 = $urandom; d1 = $urandom; rv = $urandom;
      w0 = 1'($urandom_range(0, 1)); w1 = 1'($urandom_range(0, 1)); drop = 1'($urandom_range(0, 1));
      bus_a.req0 = r0; bus_a.req1 = r1; bus_a.addr0 = a0; bus_a.addr1 = a1;
      bus_a.wdata0 = d0; bus_a.wdata1 = d1; bus_a.we0 = w0; bus_a.we1 = w1; bus_a.mem_rdata = rv;
      ep = (r0 && r1) ? (last_model ? 0 : 1) : (r0 ? 0 : 1);
      ew = (g == 0) ? 2 : 1;
      collect(1, drop, gp, wc, ec, ma, mw, mwd, st, dp, dof, ead, rdv);
      bus_a.req0 = 0; bus_a.req1 = 0;
      n_tests++; if (gp !== ep) begin n_fail++; $display("FAIL rnd_port it=%0d got %0d need %0d", it, gp, ep); end
      n_tests++; if (wc !== ew) begin n_fail++; $display("FAIL rnd_wait it=%0d got %0d need %0d", it, wc, ew); end
      n_tests++; if (ma !== (ep ? a1 : a0) || mw !== (ep ? w1 : w0) || mwd !== (ep ? d1 : d0) || !st) begin
        n_fail++; $display("FAIL rnd_mem_bus it=%0d addr=%h we=%b wdata=%h stable=%0d", it, ma, mw, mwd, st);
      end
      n_tests++; if (ec !== LAT_A || ead !== 1'b0) begin n_fail++; $display("FAIL rnd_en it=%0d cycles %0d en_at_done %b need %0d/0", it, ec, ead, LAT_A); end
      n_tests++; if (dp !== ep || dof !== LAT_A) begin n_fail++; $display("FAIL rnd_done it=%0d port %0d at +%0d need %0d at +%0d", it, dp, dof, ep, LAT_A); end
      if (!(ep ? w1 : w0)) model_rd = rv;
      n_tests++; if (rdv !== model_rd) begin n_fail++; $display("FAIL rnd_rdata it=%0d got %h need %h", it, rdv, model_rd); end
      last_model = ep[0];
    end
  endtask

  task automatic test_lat1();
    int seen;
    seen = 0;
    bus_b.mem_rdata = 32'hCAFE; bus_b.req0 = 1; bus_b.addr0 = 32'h10; bus_b.we0 = 0;
    for (int i = 0; i < 20 && !seen; i++) begin tick(); if (bus_b.gnt0) seen = 1; end
    n_tests++; if (!seen) begin n_fail++; $display("FAIL lat1_gnt0 no grant within 20 cycles"); end
    n_tests++; if (bus_b.mem_en !== 1'b1 || bus_b.mem_addr !== 32'h10) begin n_fail++; $display("FAIL lat1_bus en=%b addr=%h need 1/10", bus_b.mem_en, bus_b.mem_addr); end
    tick();
    bus_b.req0 = 0;
    n_tests++; if (bus_b.done0 !== 1'b1 || bus_b.mem_en !== 1'b0) begin n_fail++; $display("FAIL lat1_done done0=%b en=%b need 1/0", bus_b.done0, bus_b.mem_en); end
    n_tests++; if (bus_b.rdata !== 32'hCAFE) begin n_fail++; $display("FAIL lat1_rdata got %h need cafe", bus_b.rdata); end
    tick();
  endtask

  task automatic test_onehot();
    n_tests++; if (viol !== 0) begin n_fail++; $display("FAIL onehot_gnt_done %0d cycles with more than one pulse, need 0", viol); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_read();
    test_write();
    test_tie();
    test_drop();
    test_reset_busy();
    test_random();
    test_lat1();
    test_onehot();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ymem_arb.md
YMEM_ARB -- requirements
Module: ymem_arb

Interface
REQ-001 Parameter W, default 32, sets address and data width.
REQ-002 Parameter LAT, default 2, sets memory read/write latency in cycles; legal range 1..15.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req0 / req1  input  1 each  access request; port 0 is instruction fetch, port 1 is data memory.
REQ-006 addr0 / addr1  input  W each  access address per port.
REQ-007 we0 / we1  input  1 each  write enable per port; 0 = read.
REQ-008 wdata0 / wdata1  input  W each  write data per port.
REQ-009 gnt0 / gnt1  output  1 each  one-cycle grant pulse.
REQ-010 done0 / done1  output  1 each  one-cycle completion pulse.
REQ-011 rdata  output  W  read data from the last completed read.
REQ-012 mem_en  output  1  memory access strobe.
REQ-013 mem_we  output  1  memory write enable.
REQ-014 mem_addr  output  W  memory address.
REQ-015 mem_wdata  output  W  memory write data.
REQ-016 mem_rdata  input  W  memory read data, valid LAT cycles after mem_en first rises.

Function
REQ-017 The FSM SHALL have states IDLE, BUSY, RESP, with one transaction in flight at most.
REQ-018 IDLE: if req0 or req1 is sampled high, the arbiter SHALL do all of the following at that edge:
- select the winner;
- latch the winner's addr, we and wdata;
- pulse gnt of the winner for the next cycle;
- load the counter with LAT;
- enter BUSY.
REQ-019 Single request: the requesting port SHALL win.
REQ-020 Simultaneous req0 and req1: the port not granted last SHALL win (round-robin).
REQ-021 The last-granted pointer SHALL update only on a grant.
REQ-022 BUSY: mem_en SHALL be 1 for each BUSY cycle (exactly LAT cycles).
REQ-023 BUSY: mem_we, mem_addr and mem_wdata SHALL hold the latched values.
REQ-024 BUSY: the counter SHALL decrement once per cycle.
REQ-025 BUSY with counter==1: at that edge the FSM SHALL enter RESP and pulse the winner's done for one cycle.
REQ-026 On a read, rdata SHALL capture mem_rdata at that edge; on a write, rdata SHALL remain unchanged.
REQ-027 Latency: with grant visible in cycle t, done SHALL be visible in cycle t+LAT.
REQ-028 RESP SHALL return to IDLE unconditionally; no grant is issued in RESP.
REQ-029 The earliest next grant SHALL be in cycle t+LAT+2 (turnaround of 2 cycles).
REQ-030 Requesters hold req, addr, we and wdata until done; changes after grant SHALL be ignored.
REQ-031 A req dropped after grant SHALL NOT abort the transaction; done still pulses.
REQ-032 A port whose req is still high in IDLE after its done SHALL be treated as a new request.
REQ-033 Outside BUSY, mem_en and mem_we SHALL be 0; mem_addr and mem_wdata SHALL hold their last values.
REQ-034 At most one of gnt0/gnt1/done0/done1 SHALL be high in any cycle.

Reset
REQ-035 reset high at a rising edge SHALL put the FSM in IDLE and counter 0.
REQ-036 reset SHALL set the last-granted pointer to port 1, so port 0 wins the first tie.
REQ-037 reset SHALL clear to 0: gnt0/1, done0/1, rdata, mem_en, mem_we, mem_addr, mem_wdata.
REQ-038 Reset during BUSY or RESP SHALL drop the transaction without any done pulse; mem_en SHALL be 0 from the next cycle.
REQ-039 Requests sampled while reset is high SHALL be ignored.

Verification
REQ-040 Single read, LAT=2: req0=1, addr0=0x10, we0=0, mem_rdata=0xCAFE -> gnt0 in cycle t, mem_en high cycles t..t+1 with mem_addr=0x10, done0 in t+2, rdata=0xCAFE.
REQ-041 Tie after reset: req0=req1=1 held continuously -> grants alternate gnt0, gnt1, gnt0, with spacing LAT+2 cycles between grants.
REQ-042 Write: req1=1, we1=1, addr1=0x20, wdata1=0x55 -> mem_we=1, mem_addr=0x20, mem_wdata=0x55 for LAT cycles, done1 pulses, rdata unchanged.
REQ-043 Request drop: req0 deasserted the cycle after gnt0 -> transaction completes, done0 still pulses at t+LAT.
REQ-044 Reset mid-BUSY: reset asserted 1 cycle after gnt1 -> no done1, mem_en=0 next cycle, all outputs 0; subsequent tie grants port 0.
REQ-045 LAT=1 sweep: repeat REQ-040 -> done0 at t+1, mem_en high exactly 1 cycle.
